// File: rtl/operand_replay_seq_pkg.sv
// Shared constants and types for the operand replay sequencer.
package operand_replay_seq_pkg;

  // Read width and read depth of the upstream re-readable operand buffer.
  localparam int VLSU_DATA_WIDTH = 32;
  localparam int VLSU_DEPTH      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FLUSH  = 2'd3
  } replay_state_e;

endpackage

// File: rtl/operand_replay_seq.sv
// Replays a re-readable operand buffer num_passes times into one lane,
// through a single registered output stage with valid/ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_i; counters cleared
// STREAM | popping elements while the buffer has data and the lane has room
// DRAIN  | final element popped; waiting for the output register to empty
// FLUSH  | one-cycle buffer flush and done pulse, then back to IDLE
module operand_replay_seq
  import operand_replay_seq_pkg::*;
#(
  parameter int DATA_WIDTH = VLSU_DATA_WIDTH,
  parameter int DEPTH      = VLSU_DEPTH,
  parameter int PASS_W     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [PASS_W-1:0]     num_passes_i,
  input  logic                  abort_i,
  input  logic                  buf_empty_i,
  input  logic [DATA_WIDTH-1:0] buf_data_i,
  output logic                  buf_pop_o,
  output logic                  buf_flush_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_elem_o,
  output logic                  last_pass_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int            EW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [EW-1:0] ELEM_LAST = EW'(DEPTH - 1);

  replay_state_e state_q, state_d;

  logic [EW-1:0]         elem_cnt_q;
  logic [PASS_W-1:0]     pass_cnt_q;
  logic [PASS_W-1:0]     num_passes_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  last_elem_q;
  logic                  last_pass_q;

  logic pop;
  logic flush;
  logic abort_act;
  logic last_elem_now;
  logic last_pass_now;

  // Abort only has an effect while a job is actually moving data.
  assign abort_act     = abort_i & ((state_q == STREAM) | (state_q == DRAIN));
  assign last_elem_now = (elem_cnt_q == ELEM_LAST);
  assign last_pass_now = (pass_cnt_q == (num_passes_q - PASS_W'(1)));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic plus the combinational pop and flush strobes.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (num_passes_i != '0) ? STREAM : FLUSH;
      end
      STREAM: begin
        if (abort_i) begin
          state_d = FLUSH;
        end else begin
          pop = ~buf_empty_i & (~valid_q | ready_i);
          if (pop && last_elem_now && last_pass_now) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_i || !valid_q || ready_i) state_d = FLUSH;
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Element and pass counters; the stored pass count is latched with start_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_cnt_q   <= '0;
      pass_cnt_q   <= '0;
      num_passes_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      elem_cnt_q   <= '0;
      pass_cnt_q   <= '0;
      num_passes_q <= num_passes_i;
    end else if (flush) begin
      elem_cnt_q   <= '0;
      pass_cnt_q   <= '0;
      num_passes_q <= '0;
    end else if (pop) begin
      if (last_elem_now) begin
        elem_cnt_q <= '0;
        pass_cnt_q <= pass_cnt_q + PASS_W'(1);
      end else begin
        elem_cnt_q <= elem_cnt_q + EW'(1);
      end
    end
  end

  // Output register: loads on pop, empties on handshake or abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_elem_q <= 1'b0;
      last_pass_q <= 1'b0;
    end else if (pop) begin
      data_q      <= buf_data_i;
      valid_q     <= 1'b1;
      last_elem_q <= last_elem_now;
      last_pass_q <= last_pass_now;
    end else if (abort_act || (valid_q && ready_i)) begin
      valid_q <= 1'b0;
    end
  end

  assign buf_pop_o   = pop;
  assign buf_flush_o = flush;
  assign done_o      = flush;
  assign busy_o      = (state_q != IDLE);
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign last_elem_o = last_elem_q;
  assign last_pass_o = last_pass_q;

endmodule

// File: tb/tb_operand_replay_seq.sv
// Directed bench for operand_replay_seq with a re-readable buffer model and
// a per-cycle beat checker derived from pass/element arithmetic.
module tb_operand_replay_seq;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int PW    = 8;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [PW-1:0] num_passes_i;
  logic          abort_i;
  logic          buf_empty_i;
  logic [DW-1:0] buf_data_i;
  logic          buf_pop_o;
  logic          buf_flush_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_elem_o;
  logic          last_pass_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk = ~clk;

  operand_replay_seq #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PASS_W(PW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .num_passes_i(num_passes_i),
    .abort_i     (abort_i),
    .buf_empty_i (buf_empty_i),
    .buf_data_i  (buf_data_i),
    .buf_pop_o   (buf_pop_o),
    .buf_flush_o (buf_flush_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_elem_o (last_elem_o),
    .last_pass_o (last_pass_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Buffer model: first pass fills at fill_period cycles/element, then re-readable.
  logic [DW-1:0] mem [DEPTH];
  int  head, loaded, fill_period, fill_timer;
  bit  ready_toggle;
  bit  pop_seen, flush_seen;

  // Job model state, updated by the monitor.
  int exp_np, beat, done_cnt, flush_cnt, pop_cnt;
  int le_cnt, le_sum, lp_cnt, first_lp;

  // Buffer and lane driver, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_ni)        head = 0;
      else if (flush_seen) head = 0;
      else if (pop_seen)   head++;
      if (fill_period > 0 && loaded < DEPTH) begin
        fill_timer++;
        if (fill_timer >= fill_period) begin
          loaded++;
          fill_timer = 0;
        end
      end
      ready_i     = ready_toggle ? ~ready_i : 1'b1;
      buf_empty_i = (loaded < DEPTH) && (head >= loaded);
      buf_data_i  = mem[head % DEPTH];
    end
  end

  // Per-cycle monitor: latency, stall stability and beat-by-beat expectations.
  initial begin
    bit            prev_pop, prev_stall;
    logic [DW-1:0] prev_head, prev_data;
    int            k, p;
    prev_pop = 0; prev_stall = 0; prev_head = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        prev_pop = 0; prev_stall = 0; pop_seen = 0; flush_seen = 0;
      end else begin
        if (prev_pop) begin
          check("pop_to_valid", valid_o, 1);
          check("pop_data", data_o, prev_head);
        end
        if (prev_stall) begin
          check("stall_valid", valid_o, 1);
          check("stall_data", data_o, prev_data);
        end
        if (buf_pop_o) begin
          check("pop_when_empty", buf_empty_i, 0);
          pop_cnt++;
        end
        if (valid_o && ready_i) begin
          k = beat % DEPTH;
          p = beat / DEPTH;
          check("beat_data", data_o, mem[k]);
          check("beat_last_elem", last_elem_o, (k == DEPTH - 1));
          check("beat_last_pass", last_pass_o, (p == exp_np - 1));
          if (last_elem_o) begin le_cnt++; le_sum += beat + 1; end
          if (last_pass_o) begin lp_cnt++; if (first_lp == 0) first_lp = beat + 1; end
          beat++;
        end
        if (done_o) begin
          done_cnt++;
          check("done_with_flush", buf_flush_o, 1);
        end
        if (buf_flush_o) flush_cnt++;
        prev_pop   = buf_pop_o;
        prev_head  = buf_data_i;
        prev_stall = valid_o && !ready_i && !abort_i;
        prev_data  = data_o;
        pop_seen   = buf_pop_o;
        flush_seen = buf_flush_o;
      end
    end
  end

  task automatic clear_model(input int np);
    exp_np = np; beat = 0; done_cnt = 0; flush_cnt = 0; pop_cnt = 0;
    le_cnt = 0; le_sum = 0; lp_cnt = 0; first_lp = 0;
  endtask

  task automatic new_job(input int np);
    @(posedge clk); #2;
    clear_model(np);
    start_i      = 1'b1;
    num_passes_i = PW'(np);
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, (done_cnt != 0), 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_pop"}, buf_pop_o, 0);
    check({tag, "_flush"}, buf_flush_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_last_elem"}, last_elem_o, 0);
    check({tag, "_last_pass"}, last_pass_o, 0);
    check({tag, "_data"}, data_o, 0);
  endtask

  initial begin
    int n;
    rst_ni = 1'b0; start_i = 1'b0; num_passes_i = '0; abort_i = 1'b0; ready_i = 1'b1;
    head = 0; loaded = DEPTH; fill_period = 0; fill_timer = 0; ready_toggle = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    buf_empty_i = 1'b0; buf_data_i = mem[0];
    clear_model(0);
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst_ni = 1'b1;

    // Three preloaded passes, lane always ready.
    new_job(3);
    wait_done(400, "t1_timeout");
    check("t1_beats", beat, 24);
    check("t1_pops", pop_cnt, 24);
    check("t1_done", done_cnt, 1);
    check("t1_flush", flush_cnt, 1);
    check("t1_last_elem_cnt", le_cnt, 3);
    check("t1_last_elem_sum", le_sum, 48);
    check("t1_last_pass_cnt", lp_cnt, 8);
    check("t1_first_last_pass", first_lp, 17);
    check("t1_busy_after", busy_o, 0);

    // Lane ready toggling every cycle.
    ready_toggle = 1;
    new_job(3);
    wait_done(400, "t2_timeout");
    check("t2_beats", beat, 24);
    check("t2_done", done_cnt, 1);
    ready_toggle = 0;

    // First pass loading one element every three cycles.
    loaded = 0; fill_timer = 0; fill_period = 3;
    new_job(1);
    wait_done(400, "t3_timeout");
    check("t3_beats", beat, 8);
    check("t3_pops", pop_cnt, 8);
    check("t3_done", done_cnt, 1);
    fill_period = 0; loaded = DEPTH;

    // Zero passes: straight to flush, no pops.
    @(posedge clk); #2;
    clear_model(0);
    start_i = 1'b1; num_passes_i = '0;
    @(posedge clk); #2;
    start_i = 1'b0;
    check("t4_done", done_o, 1);
    check("t4_flush", buf_flush_o, 1);
    check("t4_pop", buf_pop_o, 0);
    check("t4_busy", busy_o, 1);
    @(posedge clk); #2;
    check("t4_done_end", done_o, 0);
    check("t4_busy_end", busy_o, 0);
    check("t4_pops", pop_cnt, 0);
    check("t4_done_cnt", done_cnt, 1);

    // Abort in the middle of pass 2, then a fresh job.
    new_job(3);
    n = 0;
    while (beat < 13 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("t5_reach_timeout", (beat >= 13), 1);
    #2 abort_i = 1'b1;
    @(negedge clk);
    check("t5_abort_pop", buf_pop_o, 0);
    @(posedge clk); #2;
    abort_i = 1'b0;
    check("t5_valid_drop", valid_o, 0);
    check("t5_flush_now", buf_flush_o, 1);
    wait_done(50, "t5_timeout");
    check("t5_beats", beat, 14);
    check("t5_done", done_cnt, 1);
    check("t5_flush", flush_cnt, 1);
    check("t5_idle", busy_o, 0);
    new_job(1);
    wait_done(100, "t5b_timeout");
    check("t5b_beats", beat, 8);

    // Maximum pass count.
    new_job(255);
    wait_done(3000, "t6_timeout");
    check("t6_beats", beat, 2040);
    check("t6_last_elem_cnt", le_cnt, 255);
    check("t6_last_pass_cnt", lp_cnt, 8);
    check("t6_first_last_pass", first_lp, 2033);
    check("t6_done", done_cnt, 1);

    // Reset in the middle of streaming.
    new_job(3);
    repeat (5) @(posedge clk);
    #3 rst_ni = 1'b0;
    #1;
    check_outputs_zero("t7_reset");
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("t7_no_done", done_cnt, 0);
    check("t7_idle", busy_o, 0);
    check("t7_valid", valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
